// File: rtl/xillybus_read32_arbiter.sv
// Round-robin arbiter sharing the Xillybus user_r_read_32 stream among N_REQ producers through a FIFO.
// Optional feature macro XILLY_ARB_TAG_EN: stamps the granted requester index into bits [31:28] of each word.
module xillybus_read32_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FIFO_AW   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     bus_clk,
    input  logic                     trn_reset_n,
    input  logic [32*N_REQ-1:0]      req_data,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_done,
    input  logic                     user_r_read_32_rden,
    output logic [31:0]              user_r_read_32_data,
    output logic                     user_r_read_32_empty,
    output logic                     user_r_read_32_eof,
    input  logic                     user_r_read_32_open,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int GW    = $clog2(N_REQ);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;
    typedef logic [GW-1:0]      gid_t;
    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   occ_t;
    typedef logic [BW-1:0]      cnt_t;

    state_t      state_q;
    gid_t        grant_q;
    gid_t        rr_q;
    cnt_t        burst_q;
    ptr_t        wr_ptr_q;
    ptr_t        rd_ptr_q;
    occ_t        occ_q;
    logic [31:0] data_q;
    logic        eof_q;
    logic [31:0] mem_q [DEPTH];

    logic        fifo_full;
    logic        fifo_empty;
    logic        grant_valid;
    logic        accept;
    logic        pop;
    logic        pick_found;
    gid_t        pick_idx;
    logic [31:0] wr_word;

    assign fifo_full   = (occ_q == occ_t'(DEPTH));
    assign fifo_empty  = (occ_q == '0);
    assign grant_valid = req_valid[grant_q];
    assign pop         = user_r_read_32_rden && !fifo_empty;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state_q == S_GRANT && !fifo_full && user_r_read_32_open) begin
            req_ready[grant_q] = 1'b1;
            accept             = grant_valid;
        end
    end

    // Scan starts just after the last grant, so the most recent winner gets lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % N_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = gid_t'(idx);
            end
        end
    end

    always_comb begin
        wr_word = req_data[32*int'(grant_q) +: 32];
`ifdef XILLY_ARB_TAG_EN
        wr_word[31:28] = 4'(grant_q);
`endif
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge bus_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_q     <= gid_t'(N_REQ - 1);
            burst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            data_q   <= '0;
            eof_q    <= 1'b0;
        end else if (!user_r_read_32_open) begin
            // Closing the file drops everything buffered; the round-robin position survives.
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            eof_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        rr_q    <= pick_idx;
                        burst_q <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!grant_valid) begin
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        burst_q <= burst_q + cnt_t'(1);
                        if (burst_q == cnt_t'(MAX_BURST - 1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (accept) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            occ_q <= occ_q + occ_t'(accept) - occ_t'(pop);

            if (&req_done && state_q == S_IDLE && !(|req_valid) && fifo_empty) begin
                eof_q <= 1'b1;
            end
        end
    end

    assign user_r_read_32_data  = data_q;
    assign user_r_read_32_empty = fifo_empty;
    assign user_r_read_32_eof   = eof_q;
    assign grant_id             = grant_q;

endmodule
